// File: rtl/imem_fetch_unit_pkg.sv
// Shared constants, response-source encoding and address decode helpers
// for the instruction memory fetch unit.
package imem_pkg;

    localparam int          INSTR_W_DEF  = 16;
    localparam int          ADDR_W_DEF   = 16;
    localparam int          DEPTH_DEF    = 256;
    localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_NOP  = 2'd2
    } src_e;

    typedef struct packed {
        logic [31:0] index;
        logic        misalign;
    } addr_dec_t;

    function automatic addr_dec_t decode_addr(input logic [31:0] addr, input logic byte_addr);
        addr_dec_t dec;
        if (byte_addr) begin
            dec.index    = {1'b0, addr[31:1]};
            dec.misalign = addr[0];
        end else begin
            dec.index    = addr;
            dec.misalign = 1'b0;
        end
        return dec;
    endfunction

    function automatic logic in_range(input logic [31:0] index, input int unsigned depth);
        return (index < depth);
    endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Fetch handshake and program-load bus between PC/decode/boot logic and
// the instruction memory.
interface imem_fetch_if
    import imem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_ready;
    logic               fetch_stall;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               addr_fault;
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;

    modport master (
        output fetch_req, fetch_addr, fetch_stall, load_en, load_addr, load_data,
        input  fetch_ready, instruction, instr_valid, addr_fault
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_stall, load_en, load_addr, load_data,
        output fetch_ready, instruction, instr_valid, addr_fault
    );
endinterface

// File: rtl/imem_fetch_unit_ram.sv
// Instruction storage: one synchronous write port, one synchronous read
// port, no reset on contents or read data.
module imem_ram #(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 256,
    parameter int AW      = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rdata_q;

    // Write and read ports; read data holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/imem_fetch_unit.sv
// Registered instruction fetch port with valid/ready handshake, stall hold,
// address-fault reporting and a program-load write port.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 DEPTH     = DEPTH_DEF,
    parameter bit                 BYTE_ADDR = 1'b0,
    parameter logic [INSTR_W-1:0] NOP_WORD  = INSTR_W'(NOP_WORD_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    imem_fetch_if.slave  bus
);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    addr_dec_t          fetch_dec_s;
    addr_dec_t          load_dec_s;
    logic               fetch_bad_s;
    logic               load_ok_s;
    logic               fetch_ready_s;
    logic               accept_s;
    logic               ram_we_s;
    logic               ram_re_s;
    logic [INSTR_W-1:0] ram_rdata_s;
    logic [INSTR_W-1:0] instruction_s;

    logic valid_d, valid_q;
    logic fault_d, fault_q;
    src_e src_d, src_q;

    // Address decode, handshake and port enables.
    always_comb begin
        fetch_dec_s   = decode_addr(32'(bus.fetch_addr), BYTE_ADDR);
        load_dec_s    = decode_addr(32'(bus.load_addr), BYTE_ADDR);
        fetch_bad_s   = fetch_dec_s.misalign || !in_range(fetch_dec_s.index, DEPTH);
        load_ok_s     = !load_dec_s.misalign && in_range(load_dec_s.index, DEPTH);
        fetch_ready_s = !rst && !bus.load_en && !(valid_q && bus.fetch_stall);
        accept_s      = bus.fetch_req && fetch_ready_s;
        ram_we_s      = bus.load_en && load_ok_s && !rst;
        ram_re_s      = accept_s && !fetch_bad_s;
    end

    // Response state: accept loads a new response, stall holds it, otherwise it retires.
    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        src_d   = src_q;
        if (accept_s) begin
            valid_d = 1'b1;
            fault_d = fetch_bad_s;
            src_d   = fetch_bad_s ? SRC_NOP : SRC_RAM;
        end else if (valid_q && bus.fetch_stall) begin
            valid_d = valid_q;
            fault_d = fault_q;
        end else begin
            valid_d = 1'b0;
            fault_d = 1'b0;
        end
    end

    // Response state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            src_q   <= SRC_ZERO;
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
            src_q   <= src_d;
        end
    end

    // Instruction source: the RAM read register only changes on a good accept,
    // so selecting it gives the stall hold for free.
    always_comb begin
        case (src_q)
            SRC_RAM: instruction_s = ram_rdata_s;
            SRC_NOP: instruction_s = NOP_WORD;
            default: instruction_s = {INSTR_W{1'b0}};
        endcase
    end

    imem_ram #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .AW      (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (load_dec_s.index[RAM_AW-1:0]),
        .wdata (bus.load_data),
        .re    (ram_re_s),
        .raddr (fetch_dec_s.index[RAM_AW-1:0]),
        .rdata (ram_rdata_s)
    );

    assign bus.fetch_ready = fetch_ready_s;
    assign bus.instruction = instruction_s;
    assign bus.instr_valid = valid_q;
    assign bus.addr_fault  = fault_q;
endmodule
